// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment driver.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    typedef enum logic [1:0] {
        BLANK_HI = 2'd0,
        SHOW_LO  = 2'd1,
        BLANK_LO = 2'd2,
        SHOW_HI  = 2'd3
    } seg7_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0;
    localparam logic [1:0] EN_NONE   = 2'b00;
    localparam logic [1:0] EN_LO     = 2'b01;
    localparam logic [1:0] EN_HI     = 2'b10;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    function automatic logic is_show(input seg7_state_t s);
        return (s == SHOW_LO) || (s == SHOW_HI);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment glyph decoder.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit time-multiplexed 7-segment driver with blanking dead-time between digits.
// Optional build macro: SEG7_ZERO_BLANK_EN suppresses a leading zero on the high digit.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int DEADTIME   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic [1:0] dp_in,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [1:0] en,
    output logic       frame_strobe
);

    if (DEADTIME < 1 || DEADTIME > (1 << PRESCALE_W) - 1) begin : g_bad_deadtime
        $error("seg7_mux_driver: DEADTIME must lie in 1..2**PRESCALE_W-1");
    end

    // Terminal counts: the phase counter restarts at 0 on every state change.
    localparam logic [PRESCALE_W-1:0] BLANK_LAST = PRESCALE_W'(DEADTIME - 1);
    localparam logic [PRESCALE_W-1:0] SHOW_LAST  = PRESCALE_W'((1 << PRESCALE_W) - DEADTIME - 1);

    seg7_state_t           state;
    seg7_state_t           state_nxt;
    logic [PRESCALE_W-1:0] phase;
    logic [7:0]            shadow;
    logic [1:0]            shadow_dp;

    logic                  slot_done;
    logic                  enter_lo;
    logic [3:0]            nibble_sel;
    logic [6:0]            glyph;

    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [1:0]            en_nxt;

    always_comb begin
        slot_done = is_show(state) ? (phase == SHOW_LAST) : (phase == BLANK_LAST);
        state_nxt = state;
        if (slot_done) begin
            case (state)
                BLANK_HI: state_nxt = SHOW_LO;
                SHOW_LO:  state_nxt = BLANK_LO;
                BLANK_LO: state_nxt = SHOW_HI;
                SHOW_HI:  state_nxt = BLANK_HI;
                default:  state_nxt = BLANK_HI;
            endcase
        end
        enter_lo = slot_done && (state == BLANK_HI);
    end

    // On SHOW_LO entry the shadow is being loaded this edge, so decode the live input.
    always_comb begin
        if (enter_lo) begin
            nibble_sel = value[3:0];
        end else if (state_nxt == SHOW_HI) begin
            nibble_sel = shadow[7:4];
        end else begin
            nibble_sel = shadow[3:0];
        end
    end

    hex_to_7seg u_dec (
        .nibble (nibble_sel),
        .seg    (glyph)
    );

    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b0;
        en_nxt  = EN_NONE;
        case (state_nxt)
            SHOW_LO: begin
                en_nxt  = EN_LO;
                seg_nxt = glyph;
                dp_nxt  = enter_lo ? dp_in[0] : shadow_dp[0];
            end
            SHOW_HI: begin
                en_nxt  = EN_HI;
                dp_nxt  = shadow_dp[1];
`ifdef SEG7_ZERO_BLANK_EN
                seg_nxt = (shadow[7:4] == 4'h0) ? SEG_BLANK : glyph;
`else
                seg_nxt = glyph;
`endif
            end
            default: begin
                en_nxt  = EN_NONE;
                seg_nxt = SEG_BLANK;
                dp_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BLANK_HI;
            phase        <= '0;
            shadow       <= '0;
            shadow_dp    <= '0;
            seg_out      <= SEG_BLANK;
            dp_out       <= 1'b0;
            en           <= EN_NONE;
            frame_strobe <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= slot_done ? '0 : phase + PRESCALE_W'(1);
            if (enter_lo) begin
                shadow    <= value;
                shadow_dp <= dp_in;
            end
            seg_out      <= seg_nxt;
            dp_out       <= dp_nxt;
            en           <= en_nxt;
            frame_strobe <= enter_lo;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver with PRESCALE_W=3, DEADTIME=2 (show 6, blank 2, frame 16).
module tb_seg7_mux_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] value;
    logic [1:0] dp_in;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [1:0] en;
    logic       frame_strobe;

    int total  = 0;
    int passed = 0;

    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seg7_mux_driver #(.PRESCALE_W(3), .DEADTIME(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .value        (value),
        .dp_in        (dp_in),
        .seg_out      (seg_out),
        .dp_out       (dp_out),
        .en           (en),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    function automatic logic [10:0] outs();
        return {frame_strobe, en, dp_out, seg_out};
    endfunction

    // Starts at cycle 0 of BLANK_HI, ends at cycle 0 of the next frame.
    // At index chg_idx (after its check) value/dp_in are replaced by nv/nd.
    task automatic run_frame(input string tag,
                             input logic [6:0] lo_seg, input logic lo_dp,
                             input logic [6:0] hi_seg, input logic hi_dp,
                             input int chg_idx, input logic [7:0] nv, input logic [1:0] nd);
        logic [10:0] exp;
        for (int i = 0; i < 16; i++) begin
            if (i >= 2 && i <= 7)
                exp = {(i == 2), 2'b01, lo_dp, lo_seg};
            else if (i >= 10)
                exp = {1'b0, 2'b10, hi_dp, hi_seg};
            else
                exp = 11'b0;
            chk($sformatf("%s[%0d]", tag, i), outs(), exp);
            if (i == chg_idx) begin
                value = nv;
                dp_in = nd;
            end
            tick();
        end
    endtask

    initial begin
        logic [6:0] hi_exp;
        logic [1:0] last_on;
        int zero_run, last_str, n_str;

        rst   = 1'b1;
        value = 8'h3A;
        dp_in = 2'b00;
        tick();
        tick();
        chk("reset_hold", outs(), 11'b0);
        rst = 1'b0;

        // Step 1: first two frames after reset release.
        run_frame("s1_f0", glyph[4'hA], 1'b0, glyph[4'h3], 1'b0, -1, 8'h3A, 2'b00);
        run_frame("s1_f1", glyph[4'hA], 1'b0, glyph[4'h3], 1'b0, -1, 8'h3A, 2'b00);

        // Step 2: mid-frame change to 0xF0 must wait for next frame.
        value = 8'h12;
        run_frame("s2_f0", glyph[4'h2], 1'b0, glyph[4'h1], 1'b0, 4, 8'hF0, 2'b00);
        run_frame("s2_f1", glyph[4'h0], 1'b0, glyph[4'hF], 1'b0, -1, 8'hF0, 2'b00);

        // Step 3: full byte sweep, one value per frame.
        for (int v = 0; v < 256; v++) begin
            value = 8'(v);
            dp_in = 2'(v);
            hi_exp = glyph[v >> 4];
`ifdef SEG7_ZERO_BLANK_EN
            if ((v >> 4) == 0) hi_exp = 7'b0;
`endif
            run_frame($sformatf("s3_%02h", v), glyph[v & 15], v[0], hi_exp, v[1], -1, 8'(v), 2'(v));
        end

        // Step 4: reset in the 4th SHOW_HI cycle, then the step-1 sequence again.
        value = 8'h3A;
        dp_in = 2'b00;
        run_frame("s4_pre", glyph[4'hA], 1'b0, glyph[4'h3], 1'b0, -1, 8'h3A, 2'b00);
        for (int i = 0; i < 13; i++) tick();
        chk("s4_in_show_hi", outs(), {1'b0, 2'b10, 1'b0, glyph[4'h3]});
        rst = 1'b1;
        tick();
        chk("s4_rst_blank", outs(), 11'b0);
        rst = 1'b0;
        run_frame("s4_f0", glyph[4'hA], 1'b0, glyph[4'h3], 1'b0, -1, 8'h3A, 2'b00);

        // Step 5: high-digit zero with decimal point.
        value = 8'h05;
        dp_in = 2'b10;
`ifdef SEG7_ZERO_BLANK_EN
        hi_exp = 7'b0;
`else
        hi_exp = 7'b1111110;
`endif
        run_frame("s5", 7'b1011011, 1'b0, hi_exp, 1'b1, -1, 8'h05, 2'b10);

        // Step 6: random inputs, structural timing properties.
        last_on  = 2'b00;
        zero_run = 0;
        last_str = -1;
        n_str    = 0;
        for (int c = 0; c < 10000; c++) begin
            value = 8'($urandom);
            dp_in = 2'($urandom);
            chk("s6_en_not_11", {9'b0, en}, {9'b0, (en == 2'b11) ? 2'b00 : en});
            if (en == 2'b00) begin
                zero_run++;
            end else begin
                if (last_on != 2'b00 && en != last_on)
                    chk($sformatf("s6_deadtime@%0d", c), 11'(zero_run >= 2), 11'd1);
                last_on  = en;
                zero_run = 0;
            end
            if (frame_strobe) begin
                if (last_str >= 0)
                    chk($sformatf("s6_strobe_period@%0d", c), 11'(c - last_str), 11'd16);
                last_str = c;
                n_str++;
            end
            tick();
        end
        chk("s6_strobe_count", 11'(n_str), 11'd625);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_mux_driver.md
# seg7_mux_driver

Time-multiplexed driver for a two-digit common-enable 7-segment display, sitting directly downstream of the VSLC core's 8-bit LED value output in the iCEBreaker top level. Captures the byte once per frame, alternates the two digit enables, and inserts a blanking dead-time between digits to suppress ghosting. Outputs drive the PMOD segment and enable pins through the top level.

## Interface
- `PRESCALE_W`, default 6: one digit slot lasts 2^PRESCALE_W cycles.
- `DEADTIME`, default 4: blank cycles at the end of each digit slot. Legal range 1..2^PRESCALE_W−1; any other value is an elaboration error.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  8  byte to display; `[3:0]` goes to the low digit, `[7:4]` to the high digit.
- `dp_in`  in  2  decimal points; `[0]` is the low digit, `[1]` is the high digit.
- `seg_out`  out  7  segments `{a,b,c,d,e,f,g}`, active-high.
- `dp_out`  out  1  decimal point, active-high.
- `en`  out  2  digit enables, active-high; `[0]` is the low digit, `[1]` is the high digit. Never both high.
- `frame_strobe`  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- FSM states, in cycle order: BLANK_HI → SHOW_LO → BLANK_LO → SHOW_HI → BLANK_HI …
- SHOW_* lasts 2^PRESCALE_W − DEADTIME cycles. BLANK_* lasts DEADTIME cycles. One frame is 2^(PRESCALE_W+1) cycles.
- Phase counter is PRESCALE_W bits wide:
  - Reloads at every state transition.
  - Terminal count is compared exactly, with no wrap-around ambiguity.
- On entry to SHOW_LO:
  - `value` and `dp_in` are captured into shadow registers.
  - `frame_strobe` pulses.
- Both digits in a frame come from the same captured sample. Input changes mid-frame take effect only at the next frame.
- SHOW_LO outputs: `en=2'b01`, `seg_out=hex(shadow[3:0])`, `dp_out=shadow_dp[0]`.
- SHOW_HI outputs: `en=2'b10`, `seg_out=hex(shadow[7:4])`, `dp_out=shadow_dp[1]`.
- BLANK_* outputs: `en=2'b00`, `seg_out=0`, `dp_out=0`.
- Hex encoding (`{a..g}`):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111

## Timing
- All outputs are registered. They reflect the current FSM state in the same cycle that state is held, with no combinational path from `value` to any output.
- Reset, while asserted and in the cycle after:
  - state = BLANK_HI, counter = 0, shadows = 0.
  - `en=0`, `seg_out=0`, `dp_out=0`, `frame_strobe=0`.
- After reset deasserts, BLANK_HI runs DEADTIME cycles, then SHOW_LO is entered. The first `frame_strobe` therefore occurs in cycle DEADTIME+1 after release.
- Reset asserted mid-slot: the next cycle has blank outputs and state BLANK_HI. A partial slot is never resumed.
- `value` sampled at a SHOW_LO entry is the value present on the clock edge that enters SHOW_LO. Its segments appear in that same registered cycle.
- Break-before-make: each enable transition passes through at least DEADTIME cycles with `en=0`.

## Configuration
- `SEG7_ZERO_BLANK_EN` defined:
  - When the captured `shadow[7:4]==0`, SHOW_HI drives `seg_out=0`.
  - `en[1]` still asserts, and `dp_out` is still `shadow_dp[1]`.
- Macro not defined: the high digit always shows its hex glyph, including "0".
- Low digit behaviour is identical in both builds.

## Structure
- Package `seg7_pkg` holds:
  - the state enum (BLANK_HI, SHOW_LO, BLANK_LO, SHOW_HI)
  - localparams `SEG_BLANK=7'b0` and `EN_NONE=2'b00`
  - the 16 glyph constants.
- Sub-module `hex_to_7seg`: purely combinational 4-bit to 7-bit decoder, instantiated once and muxed between the two shadow nibbles.

## Test plan
All scenarios use `PRESCALE_W=3`, `DEADTIME=2`, giving show=6, blank=2, frame=16.
1. Release reset with `value=8'h3A`, `dp_in=0`:
   - 2 blank cycles, then 6 cycles of `en=01`, `seg=1110111`.
   - Then 2 blank cycles, then 6 cycles of `en=10`, `seg=1111001`.
   - `frame_strobe` pulses in cycle 3 and every 16 cycles after.
2. Change `value` from 8'h12 to 8'hF0 at the 3rd cycle of SHOW_LO:
   - SHOW_HI of that frame still shows 0110000.
   - Next frame's low digit shows 1111110, high digit shows 1000111.
3. Sweep `value` 0x00..0xFF, one value per frame: every nibble decodes per the glyph list in both slots.
4. Assert `rst` during the 4th cycle of SHOW_HI:
   - Next cycle all outputs are 0.
   - After release, the step-1 sequence repeats exactly.
5. `value=8'h05`, `dp_in=2'b10`:
   - Without `SEG7_ZERO_BLANK_EN`: SHOW_HI gives `seg=1111110`, `dp=1`.
   - With it: `seg=0`, `dp=1`, `en=10`.
6. Continuous random `value`/`dp_in` over 10,000 cycles:
   - `en` is never 2'b11.
   - Every 01↔10 change passes through ≥2 cycles of `en=00`.
   - `frame_strobe` period is exactly 16 cycles.
